// File: rtl/reg_file_pkg.sv
// Shared widths and helpers for the architectural register file with rename tags.
package reg_file_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned REG_IDX_W     = 5;
    localparam int unsigned REG_NUM_DEF   = 32;
    localparam int unsigned ROB_IDX_W_DEF = 4;

    // x0 is hardwired to zero: never renamed, never written, always reads ready/zero.
    function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One source-operand lookup: register state read, x0 forcing, and same-cycle commit bypass.
// Ports:
//   idx_i                     - architectural register being read
//   val_i / busy_i / tag_i    - current register file state (all registers)
//   commit_en_i/idx_i/dest_i/val_i - ROB commit stream, used for the bypass
//   busy_c_o / val_c_o / dep_c_o   - combinational operand status, value and ROB tag
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM      = REG_NUM_DEF,
    parameter int unsigned ROB_IDX_SIZE = ROB_IDX_W_DEF
) (
    input  logic [REG_IDX_W-1:0]                   idx_i,
    input  logic [REG_NUM-1:0][DATA_W-1:0]         val_i,
    input  logic [REG_NUM-1:0]                     busy_i,
    input  logic [REG_NUM-1:0][ROB_IDX_SIZE-1:0]   tag_i,
    input  logic                                   commit_en_i,
    input  logic [ROB_IDX_SIZE-1:0]                commit_idx_i,
    input  logic [REG_IDX_W-1:0]                   commit_dest_i,
    input  logic [DATA_W-1:0]                      commit_val_i,
    output logic                                   busy_c_o,
    output logic [DATA_W-1:0]                      val_c_o,
    output logic [ROB_IDX_SIZE-1:0]                dep_c_o
);

    logic hit_commit;

    // The retiring entry is exactly the producer this register waits on.
    assign hit_commit = busy_i[idx_i] && commit_en_i &&
                        (commit_dest_i == idx_i) && (tag_i[idx_i] == commit_idx_i);

    always_comb begin
        busy_c_o = busy_i[idx_i];
        val_c_o  = val_i[idx_i];
        dep_c_o  = tag_i[idx_i];
        if (is_zero_reg(idx_i)) begin
            busy_c_o = 1'b0;
            val_c_o  = '0;
            dep_c_o  = '0;
        end else if (hit_commit) begin
            busy_c_o = 1'b0;
            val_c_o  = commit_val_i;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags, between decoder and reorder buffer.
// Ports:
//   clk, rst_in (async, active-low), rdy_in (hold all state when low)
//   roll_back                      - flash-clear every rename
//   rob_commit_*                   - retired result write-back from the ROB
//   de_rename_*                    - decoder destination rename request
//   de_rs1_idx_in / de_rs2_idx_in  - source operand indices
//   rsN_busy_out/val_out/dep_out   - combinational operand status, value, ROB tag
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM      = REG_NUM_DEF,
    parameter int unsigned ROB_IDX_SIZE = ROB_IDX_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     roll_back,
    input  logic                     rob_commit_en,
    input  logic [ROB_IDX_SIZE-1:0]  rob_commit_idx,
    input  logic [REG_IDX_W-1:0]     rob_commit_dest,
    input  logic [DATA_W-1:0]        rob_commit_val,
    input  logic                     de_rename_en,
    input  logic [REG_IDX_W-1:0]     de_rename_rd,
    input  logic [ROB_IDX_SIZE-1:0]  de_rename_rob_idx,
    input  logic [REG_IDX_W-1:0]     de_rs1_idx_in,
    input  logic [REG_IDX_W-1:0]     de_rs2_idx_in,
    output logic                     rs1_busy_out,
    output logic [DATA_W-1:0]        rs1_val_out,
    output logic [ROB_IDX_SIZE-1:0]  rs1_dep_out,
    output logic                     rs2_busy_out,
    output logic [DATA_W-1:0]        rs2_val_out,
    output logic [ROB_IDX_SIZE-1:0]  rs2_dep_out
);

    logic [REG_NUM-1:0][DATA_W-1:0]       val_q,  val_d;
    logic [REG_NUM-1:0]                   busy_q, busy_d;
    logic [REG_NUM-1:0][ROB_IDX_SIZE-1:0] tag_q,  tag_d;

    // Next state: commit first, then rename/roll_back so they take priority on busy/tag.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rob_commit_en && !is_zero_reg(rob_commit_dest)) begin
            val_d[rob_commit_dest] = rob_commit_val;
            // Only the youngest producer may release the register.
            if (busy_q[rob_commit_dest] && (tag_q[rob_commit_dest] == rob_commit_idx)) begin
                busy_d[rob_commit_dest] = 1'b0;
            end
        end
        if (roll_back) begin
            busy_d = '0;
        end else if (de_rename_en && !is_zero_reg(de_rename_rd)) begin
            busy_d[de_rename_rd] = 1'b1;
            tag_d[de_rename_rd]  = de_rename_rob_idx;
        end
    end

    // State register; rdy_in low freezes everything including roll_back.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else if (rdy_in) begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    reg_read_port #(.REG_NUM(REG_NUM), .ROB_IDX_SIZE(ROB_IDX_SIZE)) u_rs1 (
        .idx_i         (de_rs1_idx_in),
        .val_i         (val_q),
        .busy_i        (busy_q),
        .tag_i         (tag_q),
        .commit_en_i   (rob_commit_en),
        .commit_idx_i  (rob_commit_idx),
        .commit_dest_i (rob_commit_dest),
        .commit_val_i  (rob_commit_val),
        .busy_c_o      (rs1_busy_out),
        .val_c_o       (rs1_val_out),
        .dep_c_o       (rs1_dep_out)
    );

    reg_read_port #(.REG_NUM(REG_NUM), .ROB_IDX_SIZE(ROB_IDX_SIZE)) u_rs2 (
        .idx_i         (de_rs2_idx_in),
        .val_i         (val_q),
        .busy_i        (busy_q),
        .tag_i         (tag_q),
        .commit_en_i   (rob_commit_en),
        .commit_idx_i  (rob_commit_idx),
        .commit_dest_i (rob_commit_dest),
        .commit_val_i  (rob_commit_val),
        .busy_c_o      (rs2_busy_out),
        .val_c_o       (rs2_val_out),
        .dep_c_o       (rs2_dep_out)
    );

endmodule
